// File: rtl/nibble_exec.sv
// nibble_exec: execute stage of a 4-bit nibble processor.
//
// Sequences FETCH -> EXEC for one-byte instructions and
// FETCH -> EXEC -> FETCH2 -> JUMP for two-byte jumps. It drives the
// PC/fetch enables of the upstream stage and holds the accumulator, the
// flags and the output data register.
//
// Build option: define NIBBLE_EXEC_HALT_EN so that opcode 0xF halts the core.
// Without it, 0xF is a NOP and halted is tied low.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   inst, oprnd    opcode / operand nibbles from the fetch register
//   data_in        RAM/input-port data, sampled in EXEC
//   enable_counter PC increment enable
//   enable_fetch   fetch-register load enable
//   load_counter   PC load strobe (PC <= jump_addr)
//   jump_addr      jump target {hi_nibble, inst, oprnd}
//   accu           accumulator
//   c_flag, z_flag carry/borrow flag and zero flag
//   data_out       registered data for OUT/STM
//   out_we, ram_we one-cycle write strobes
//   halted         high while in HALT
module nibble_exec #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        inst,
    input  logic [3:0]        oprnd,
    input  logic [3:0]        data_in,
    output logic              enable_counter,
    output logic              enable_fetch,
    output logic              load_counter,
    output logic [ADDR_W-1:0] jump_addr,
    output logic [3:0]        accu,
    output logic              c_flag,
    output logic              z_flag,
    output logic [3:0]        data_out,
    output logic              out_we,
    output logic              ram_we,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_FETCH2,
        S_JUMP,
        S_HALT
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] accu_q, accu_d;
    logic       c_q, c_d;
    logic       z_q, z_d;
    logic [3:0] dout_q, dout_d;
    logic [3:0] hi_q, hi_d;
    logic       cond_q, cond_d;
`ifdef NIBBLE_EXEC_HALT_EN
    logic       halted_q, halted_d;
`endif

    logic [3:0] addend;
    logic [4:0] sum;
    logic [3:0] nand_res;

    always_comb begin
        addend   = (inst == 4'h5) ? data_in : oprnd;
        sum      = {1'b0, accu_q} + {1'b0, addend};
        nand_res = ~(accu_q & oprnd);

        state_d = state_q;
        accu_d  = accu_q;
        c_d     = c_q;
        z_d     = z_q;
        dout_d  = dout_q;
        hi_d    = hi_q;
        cond_d  = cond_q;
`ifdef NIBBLE_EXEC_HALT_EN
        halted_d = halted_q;
`endif

        case (state_q)
            S_FETCH:  state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_FETCH;
                case (inst)
                    4'h1: begin
                        accu_d = oprnd;
                        z_d    = (oprnd == 4'h0);
                    end
                    4'h2: begin
                        accu_d = data_in;
                        z_d    = (data_in == 4'h0);
                    end
                    4'h3, 4'hE: dout_d = accu_q;
                    4'h4, 4'h5: begin
                        accu_d = sum[3:0];
                        c_d    = sum[4];
                        z_d    = (sum[3:0] == 4'h0);
                    end
                    4'h6: begin
                        accu_d = accu_q - oprnd;
                        c_d    = (accu_q < oprnd);
                        z_d    = (accu_q == oprnd);
                    end
                    4'h7: begin
                        accu_d = nand_res;
                        z_d    = (nand_res == 4'h0);
                    end
                    4'h8: begin
                        c_d = (accu_q < oprnd);
                        z_d = (accu_q == oprnd);
                    end
                    4'h9, 4'hA, 4'hB, 4'hC, 4'hD: begin
                        // Condition is frozen from the flags at this edge;
                        // nothing between here and JUMP can change them.
                        hi_d    = oprnd;
                        state_d = S_FETCH2;
                        case (inst)
                            4'hA:    cond_d = c_q;
                            4'hB:    cond_d = ~c_q;
                            4'hC:    cond_d = z_q;
                            4'hD:    cond_d = ~z_q;
                            default: cond_d = 1'b1;
                        endcase
                    end
`ifdef NIBBLE_EXEC_HALT_EN
                    4'hF: begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
            S_FETCH2: state_d = S_JUMP;
            S_JUMP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            accu_q  <= '0;
            c_q     <= 1'b0;
            z_q     <= 1'b0;
            dout_q  <= '0;
            hi_q    <= '0;
            cond_q  <= 1'b0;
`ifdef NIBBLE_EXEC_HALT_EN
            halted_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            accu_q  <= accu_d;
            c_q     <= c_d;
            z_q     <= z_d;
            dout_q  <= dout_d;
            hi_q    <= hi_d;
            cond_q  <= cond_d;
`ifdef NIBBLE_EXEC_HALT_EN
            halted_q <= halted_d;
`endif
        end
    end

    // Strobes are decoded from state and opcode only, gated by reset so they
    // stay low while reset is held even though the state sits in FETCH.
    always_comb begin
        enable_fetch   = reset && ((state_q == S_FETCH) || (state_q == S_FETCH2));
        enable_counter = enable_fetch;
        load_counter   = reset && (state_q == S_JUMP) && cond_q;
        out_we         = reset && (state_q == S_EXEC) && (inst == 4'h3);
        ram_we         = reset && (state_q == S_EXEC) && (inst == 4'hE);
    end

    assign jump_addr = {hi_q, inst, oprnd};
    assign accu      = accu_q;
    assign c_flag    = c_q;
    assign z_flag    = z_q;
    assign data_out  = dout_q;
`ifdef NIBBLE_EXEC_HALT_EN
    assign halted    = halted_q;
`else
    assign halted    = 1'b0;
`endif

endmodule

// File: doc/nibble_exec.md
NIBBLE_EXEC -- requirements
Module: nibble_exec

Interface
REQ-001 Parameter: ADDR_W, 12, program-counter and jump-target width; the block SHALL support only ADDR_W = 12 (4-bit operand high nibble + 8-bit second byte).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 inst  input  4  opcode from the upstream fetch register (program_byte[7:4]).
REQ-005 oprnd  input  4  operand from the upstream fetch register (program_byte[3:0]).
REQ-006 data_in  input  4  data from RAM/input port, sampled in EXEC.
REQ-007 enable_counter  output  1  PC increment enable to the upstream stage.
REQ-008 enable_fetch  output  1  fetch-register load enable to the upstream stage.
REQ-009 load_counter  output  1  PC load strobe; the PC takes jump_addr on that edge.
REQ-010 jump_addr  output  ADDR_W  jump target {hi_nibble, inst, oprnd}.
REQ-011 accu  output  4  accumulator.
REQ-012 c_flag, z_flag  output  1 each  carry/borrow flag and zero flag.
REQ-013 data_out  output  4  registered data for OUT/STM.
REQ-014 out_we, ram_we  output  1 each  one-cycle write strobes for the output port and RAM.
REQ-015 halted  output  1  high while in HALT.

Function
REQ-016 FSM states SHALL be FETCH, EXEC, FETCH2, JUMP, HALT; the state after reset SHALL be FETCH.
REQ-017 FETCH: enable_fetch = enable_counter = 1 for one cycle -> EXEC.
REQ-018 EXEC, opcodes 0x0-0x8 and 0xE: execute in one cycle -> FETCH.
REQ-019 Opcodes: 0x0 NOP; 0x1 LIT A=oprnd; 0x2 IN A=data_in; 0x3 OUT data_out=A, out_we=1; 0x4 ADDI {C,A}=A+oprnd; 0x5 ADDM {C,A}=A+data_in; 0x6 SUBI A=A-oprnd, C=(A<oprnd); 0x7 NANDI A=~(A&oprnd), C unchanged; 0x8 CMPI flags only: Z=(A==oprnd), C=(A<oprnd); 0xE STM data_out=A, ram_we=1.
REQ-020 Z SHALL equal (result==0) after LIT, IN, ADDI, ADDM, SUBI, NANDI; NOP, OUT and STM SHALL leave A, C and Z unchanged.
REQ-021 Arithmetic SHALL be 4-bit modulo-16 with the 5th bit into C (e.g. 0xF+0x1 -> A=0, C=1, Z=1).
REQ-022 Jumps (two bytes): 0x9 JMP always, 0xA JC, 0xB JNC, 0xC JZ, 0xD JNZ; in EXEC, oprnd SHALL latch into hi_nibble and the condition SHALL latch from the flags at that edge -> FETCH2.
REQ-023 FETCH2: enable_fetch = enable_counter = 1 -> JUMP.
REQ-024 JUMP: jump_addr = {hi_nibble, inst, oprnd}; load_counter = 1 only if the condition is true; enable_counter = 0 -> FETCH.
REQ-025 A not-taken jump SHALL still consume its second byte, so execution continues at the jump address + 2.
REQ-026 enable_fetch, enable_counter, load_counter, out_we and ram_we SHALL be decoded from the state and opcode only, without combinational paths from data_in.
REQ-027 load_counter and enable_counter SHALL never both be 1 in the same cycle.
REQ-028 Opcode 0xF SHALL behave per the configuration option.
REQ-029 HALT: all enables and strobes 0, halted = 1, state held until reset.

Reset
REQ-030 reset low SHALL asynchronously force: state = FETCH, accu = 0, c_flag = 0, z_flag = 0, data_out = 0, hi_nibble = 0, halted = 0.
REQ-031 While reset is low, enable_fetch, enable_counter, load_counter, out_we and ram_we SHALL be 0.
REQ-032 Reset asserted mid-jump (FETCH2 or JUMP) SHALL abort the jump with no load_counter pulse.
REQ-033 The first FETCH SHALL occur in the first cycle after reset is released.

Configuration
REQ-034 With NIBBLE_EXEC_HALT_EN defined, opcode 0xF SHALL enter HALT from EXEC.
REQ-035 Without NIBBLE_EXEC_HALT_EN, opcode 0xF SHALL execute as NOP and halted SHALL be tied to 0.

Verification
REQ-036 Bench SHALL cover: LIT 0x7, ADDI 0x9 -> accu = 0x0, c_flag = 1, z_flag = 1; each instruction takes 2 cycles.
REQ-037 Bench SHALL cover: LIT 0x3, SUBI 0x5 -> accu = 0xE, c_flag = 1, z_flag = 0; then CMPI 0xE -> z_flag = 1, c_flag = 0, accu unchanged.
REQ-038 Bench SHALL cover: bytes 0x91, 0x23 (JMP 0x123) -> load_counter = 1 for one cycle in the 4th cycle with jump_addr = 0x123, enable_counter = 0 in that cycle.
REQ-039 Bench SHALL cover: z_flag = 0, then JZ 0x0_40 -> no load_counter pulse; the next FETCH reads the byte after the second jump byte.
REQ-040 Bench SHALL cover: LIT 0xA, OUT -> out_we = 1 for exactly one cycle with data_out = 0xA; STM -> ram_we = 1 for one cycle.
REQ-041 Bench SHALL cover: opcode 0xF -> with NIBBLE_EXEC_HALT_EN, halted = 1 and no further fetch enables until reset low; without it, execution continues.
